// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch stage: drives a 1-cycle-latency instruction memory, buffers
// returned words in a small prefetch queue and hands {instruction, pc} to decode.
module fetch_prefetch_unit #(
  parameter int          DEPTH       = 4,
  parameter logic [7:0]  RESET_PC    = 8'h00,
  parameter logic [3:0]  HALT_OPCODE = 4'hF,
  localparam int         LW          = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic          redirect,
  input  logic [7:0]    redirect_pc,
  output logic          imem_req,
  output logic [7:0]    imem_addr,
  input  logic [15:0]   imem_rdata,
  output logic [15:0]   instruction,
  output logic [7:0]    pc_out,
  output logic          valid,
  output logic          update,
  output logic          halt,
  output logic [LW-1:0] queue_level
);

  localparam int PW = $clog2(DEPTH);

  logic [7:0]    fetch_pc_q, fetch_pc_d;
  logic          inflight_q, inflight_d;
  logic [7:0]    inflight_pc_q, inflight_pc_d;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [LW-1:0] level_q, level_d;
  logic [15:0]   instr_q, instr_d;
  logic [7:0]    pc_out_q, pc_out_d;
  logic          valid_q, valid_d;
  logic          update_q, update_d;
  logic          halt_q, halt_d;
  logic          push, pop;
  logic [23:0]   entries_q [DEPTH];
  logic [LW:0]   occupancy;

  // Outstanding request counts against queue space so a response always has a slot.
  assign occupancy = {1'b0, level_q} + {{LW{1'b0}}, inflight_q};
  assign imem_req  = !halt_q && !redirect && (occupancy < (LW+1)'(DEPTH));
  assign imem_addr = fetch_pc_q;

  // Decode handshake: valid marks a real instruction; stall with valid=1 holds
  // instruction/pc_out/valid; a new word is loaded when !valid || !stall.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = inflight_q;
    inflight_pc_d = inflight_pc_q;
    head_d        = head_q;
    tail_d        = tail_q;
    level_d       = level_q;
    instr_d       = instr_q;
    pc_out_d      = pc_out_q;
    valid_d       = valid_q;
    update_d      = 1'b0;
    halt_d        = halt_q;
    push          = 1'b0;
    pop           = 1'b0;
    if (halt_q) begin
      head_d     = '0;
      tail_d     = '0;
      level_d    = '0;
      inflight_d = 1'b0;
    end else if (redirect) begin
      head_d     = '0;
      tail_d     = '0;
      level_d    = '0;
      inflight_d = 1'b0;
      valid_d    = 1'b0;
      fetch_pc_d = redirect_pc;
    end else begin
      push       = inflight_q;
      pop        = (level_q != '0) && (!valid_q || !stall);
      inflight_d = imem_req;
      if (imem_req) begin
        fetch_pc_d    = fetch_pc_q + 8'd1;
        inflight_pc_d = fetch_pc_q;
      end
      if (push) tail_d = tail_q + PW'(1);
      if (pop) begin
        head_d                = head_q + PW'(1);
        {pc_out_d, instr_d}   = entries_q[head_q];
        valid_d               = 1'b1;
        update_d              = 1'b1;
        if (entries_q[head_q][15:12] == HALT_OPCODE) halt_d = 1'b1;
      end else if (!stall) begin
        valid_d = 1'b0;
      end
      case ({push, pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 8'h00;
      head_q        <= '0;
      tail_q        <= '0;
      level_q       <= '0;
      instr_q       <= 16'h0000;
      pc_out_q      <= 8'h00;
      valid_q       <= 1'b0;
      update_q      <= 1'b0;
      halt_q        <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      level_q       <= level_d;
      instr_q       <= instr_d;
      pc_out_q      <= pc_out_d;
      valid_q       <= valid_d;
      update_q      <= update_d;
      halt_q        <= halt_d;
    end
  end

  // Each entry carries the address it was fetched from alongside the word.
  always_ff @(posedge clk) begin
    if (push) entries_q[tail_q] <= {inflight_pc_q, imem_rdata};
  end

  assign instruction = instr_q;
  assign pc_out      = pc_out_q;
  assign valid       = valid_q;
  assign update      = update_q;
  assign halt        = halt_q;
  assign queue_level = level_q;

endmodule

// File: doc/fetch_prefetch_unit.md
Name: fetch_prefetch_unit

Overview:
- Instruction-fetch stage upstream of the pipelined datapath's decode stage.
- Maintains the fetch PC and issues reads to a synchronous instruction memory (1-cycle read latency).
- Buffers returned words in a small prefetch queue and presents one {instruction, PC} pair per cycle to decode.
- Honours hazard-unit stalls, branch/jump redirects and a sticky HALT.

Parameters:
DEPTH, 4, prefetch queue entries (power of 2, ≥2)
RESET_PC, 8'h00, first fetch address after reset
HALT_OPCODE, 4'hF, value of instruction[15:12] that halts fetch

Ports:
clk  in  1  clock
reset  in  1  reset
stall  in  1  hazard stall; hold decode-side output
redirect  in  1  taken branch/jump/flush; discard all fetched state
redirect_pc  in  8  new fetch address when redirect=1
imem_req  out  1  instruction-memory read request
imem_addr  out  8  read address
imem_rdata  in  16  read data, valid the cycle after imem_req=1
instruction  out  16  instruction to decode
pc_out  out  8  PC of instruction
valid  out  1  instruction/pc_out hold a real instruction
update  out  1  1-cycle pulse: output register loaded a new instruction this edge
halt  out  1  sticky; HALT instruction reached decode
queue_level  out  $clog2(DEPTH+1)  current queue occupancy

Behaviour:
- Reset is asynchronous, active-high, on clk. Reset values: fetch_pc=RESET_PC, queue empty, inflight=0, instruction=16'h0000, pc_out=8'h00, valid=0, update=0, halt=0, queue_level=0. Reset mid-operation discards everything; the response to any pre-reset request is ignored.
- Request issue (combinational):
  - imem_req = !halt && !redirect && (queue_level + inflight < DEPTH).
  - imem_addr = fetch_pc.
  - On issue, fetch_pc increments by 1 modulo 256 (8'hFF→8'h00). inflight <= imem_req.
- Response: when inflight=1 and no redirect this cycle, {fetch address, imem_rdata} is pushed at the queue tail at the cycle edge. Each request tracks its own PC.
- Output load: when the queue is non-empty and (!valid || !stall), the head is popped into instruction/pc_out, with valid<=1 and update<=1. Otherwise update<=0.
- When the queue is empty and the output register is not stalled, valid<=0 (bubble).
- Push and pop in the same cycle are allowed; level is unchanged.
- Latency: first request in cycle 0 after reset release; rdata in cycle 1; queued at the end of cycle 1; output loaded at the end of cycle 2. valid=1 with pc_out=RESET_PC in cycle 3.
- Steady state delivers 1 instruction/cycle.
- Stall with valid=1: instruction, pc_out and valid hold. The queue keeps filling until level+inflight=DEPTH, then imem_req=0. No instruction is lost or duplicated. On release, sequential PCs resume.
- Redirect (priority over stall and over any response/pop in the same cycle):
  - At the edge: queue cleared, inflight cleared (the response arriving this cycle is dropped), valid<=0, update<=0, fetch_pc<=redirect_pc. imem_req=0 during the redirect cycle.
  - Cycle r+1: request at redirect_pc. valid=1 with pc_out=redirect_pc in cycle r+4 (3 bubbles).
- Halt:
  - When a popped head has instruction[15:12]=HALT_OPCODE and no redirect occurs that cycle, the word is loaded (valid=1, update=1) and halt<=1 at the same edge.
  - While halt=1: imem_req=0, the queue is cleared, no further loads occur, valid/instruction/pc_out hold the HALT word, and redirect is ignored.
  - Only reset clears halt.
  - A redirect in the same cycle as a HALT pop discards the HALT word; halt stays 0.

Test Plan:
- Reset release; imem returns word=16'h1000+addr → valid first high in cycle 3 with pc_out=00, instruction=1000. Following cycles give PCs 01,02,03… back-to-back, with update=1 each cycle.
- Stall held 8 cycles while valid=1 → outputs frozen; queue_level reaches 4 (DEPTH) and imem_req=0. After release, PCs continue consecutively with no gap or repeat.
- redirect=1 with redirect_pc=8'h40 while streaming → imem_req=0 that cycle; the dropped response is never output; valid=0 for 3 cycles; then pc_out=40,41,… .
- redirect and stall asserted in the same cycle with queue_level=3 → redirect wins: queue_level=0, valid=0, next output pc_out=redirect_pc.
- Word 16'hF000 at address 05 → halt=1 when pc_out=05. No further imem_req; a later redirect is ignored. Reset restarts from RESET_PC with halt=0.
- Start with redirect_pc=8'hFE → outputs pc_out FE, FF, 00, 01 (wrap). Asserting reset mid-stream clears valid and queue_level immediately, and the next output is pc_out=00.
